// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N:1 round-robin or fixed-priority arbiter feeding a single registered output beat
module rr_arb_mux #(
  parameter int WIDTH = 16,
  parameter int N = 16,
  parameter int RR = 1,
  localparam int SW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               force_en,
  input  logic [SW-1:0]      force_sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
);

  logic [N-1:0]     elig;
  logic             load_en;
  logic             found;
  logic             grant;
  logic [SW-1:0]    base;
  logic [SW-1:0]    idx;
  logic [SW-1:0]    g;

  logic [SW-1:0]    ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;

  always_comb begin
    elig = in_valid;
    if (force_en) begin
      elig = '0;
      elig[force_sel] = in_valid[force_sel];
    end
  end

  assign load_en = !out_valid_q || out_ready;

  // N is a power of two, so adding to the pointer wraps naturally at SW bits.
  always_comb begin
    base  = (RR != 0) ? ptr_q : '0;
    g     = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = base + SW'(k);
      if (!found && elig[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end

  // in_ready is derived only from valid/force/state, never from in_data.
  assign grant = load_en && found && !reset;

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[g] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = grant || (out_valid_q && !out_ready);
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (grant) begin
      if (RR != 0) ptr_d = g + 1'b1;
      out_data_d = in_data[int'(g)*WIDTH +: WIDTH];
      out_sel_d  = g;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed and scoreboarded checks of rr_arb_mux in RR, fixed-priority and 16-channel forms
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [3:0]  a_in_valid, a_in_ready, b_in_valid, b_in_ready;
  logic [63:0] a_in_data, b_in_data;
  logic        a_force_en, b_force_en, a_out_valid, b_out_valid, a_out_ready, b_out_ready;
  logic [1:0]  a_force_sel, b_force_sel, a_out_sel, b_out_sel;
  logic [15:0] a_out_data, b_out_data;

  logic [15:0]  c_in_valid, c_in_ready;
  logic [127:0] c_in_data;
  logic         c_force_en, c_out_valid, c_out_ready;
  logic [3:0]   c_force_sel, c_out_sel;
  logic [7:0]   c_out_data;

  rr_arb_mux #(.WIDTH(16), .N(4), .RR(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .force_en(a_force_en), .force_sel(a_force_sel), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_ready(a_out_ready));

  rr_arb_mux #(.WIDTH(16), .N(4), .RR(0)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .force_en(b_force_en), .force_sel(b_force_sel), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_ready(b_out_ready));

  rr_arb_mux #(.WIDTH(8), .N(16), .RR(1)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .force_en(c_force_en), .force_sel(c_force_sel), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_ready(c_out_ready));

  task automatic test_reset();
    reset = 1'b1;
    a_in_valid = 4'hF; a_in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000}; a_out_ready = 1'b1;
    a_force_en = 1'b0; a_force_sel = 2'd0;
    b_in_valid = 4'h0; b_in_data = {16'hB003, 16'hB002, 16'hB001, 16'hB000}; b_out_ready = 1'b1;
    b_force_en = 1'b0; b_force_sel = 2'd0;
    c_in_valid = '0; c_in_data = '0; c_out_ready = 1'b1; c_force_en = 1'b0; c_force_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_out_sel !== 2'd0) begin
      errors++; $display("FAIL reset_out actual v=%b d=%h s=%0d required 0 0 0", a_out_valid, a_out_data, a_out_sel);
    end
    checks++;
    if (a_in_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_in_ready actual %b required 0000", a_in_ready);
    end
    checks++;
    if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_other actual b=%b c=%b required 0 0", b_out_valid, c_out_valid);
    end
    @(negedge clk);
    reset = 1'b0; a_in_valid = 4'h0;
  endtask

  task automatic test_rr_sequence();
    logic [1:0] es;
    logic [3:0] er;
    @(negedge clk);
    a_in_valid = 4'hF; a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_first_ready actual %b required 0001", a_in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      es = 2'(k % 4);
      er = 4'b0001 << ((k + 1) % 4);
      checks++;
      if (a_out_valid !== 1'b1 || a_out_sel !== es || a_out_data !== (16'hA000 + 16'(k % 4))) begin
        errors++; $display("FAIL rr_seq%0d actual v=%b s=%0d d=%h required 1 %0d %h", k, a_out_valid, a_out_sel, a_out_data, es, 16'hA000 + 16'(k % 4));
      end
      checks++;
      if (a_in_ready !== er) begin
        errors++; $display("FAIL rr_ready%0d actual %b required %b", k, a_in_ready, er);
      end
    end
    @(negedge clk);
    a_in_valid = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_sel !== 2'd0 || a_out_data !== 16'hA000) begin
      errors++; $display("FAIL rr_drain actual v=%b s=%0d d=%h required 0 0 a000", a_out_valid, a_out_sel, a_out_data);
    end
  endtask

  task automatic test_fixed_priority();
    @(negedge clk);
    b_in_valid = 4'b1010; b_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (b_in_ready !== 4'b0010) begin
        errors++; $display("FAIL fp_ready%0d actual %b required 0010", k, b_in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (b_out_valid !== 1'b1 || b_out_sel !== 2'd1 || b_out_data !== 16'hB001) begin
        errors++; $display("FAIL fp_out%0d actual v=%b s=%0d d=%h required 1 1 b001", k, b_out_valid, b_out_sel, b_out_data);
      end
      @(negedge clk);
    end
    b_in_valid = 4'h0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_in_data[47:32] = 16'hBEEF; a_in_valid = 4'b0100; a_out_ready = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_grant actual %b required 0100", a_in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 16'hBEEF || a_out_sel !== 2'd2) begin
      errors++; $display("FAIL bp_load actual v=%b d=%h s=%0d required 1 beef 2", a_out_valid, a_out_data, a_out_sel);
    end
    @(negedge clk);
    a_in_valid = 4'hF; a_in_data[47:32] = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (a_in_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_stall_ready%0d actual %b required 0000", k, a_in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 16'hBEEF || a_out_sel !== 2'd2) begin
        errors++; $display("FAIL bp_hold%0d actual v=%b d=%h s=%0d required 1 beef 2", k, a_out_valid, a_out_data, a_out_sel);
      end
      @(negedge clk);
    end
    a_out_ready = 1'b1; a_in_valid = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 16'hBEEF) begin
      errors++; $display("FAIL bp_consume actual v=%b d=%h required 0 beef", a_out_valid, a_out_data);
    end
    a_in_data[47:32] = 16'hA002;
  endtask

  task automatic test_force();
    @(negedge clk);
    a_in_valid = 4'b0001; a_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_out_sel !== 2'd0 || a_out_valid !== 1'b1) begin
      errors++; $display("FAIL force_pre actual s=%0d v=%b required 0 1", a_out_sel, a_out_valid);
    end
    @(negedge clk);
    a_force_en = 1'b1; a_force_sel = 2'd3; a_in_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (a_in_ready !== 4'b1000) begin
        errors++; $display("FAIL force_ready%0d actual %b required 1000", k, a_in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (a_out_sel !== 2'd3 || a_out_data !== 16'hA003) begin
        errors++; $display("FAIL force_out%0d actual s=%0d d=%h required 3 a003", k, a_out_sel, a_out_data);
      end
      @(negedge clk);
    end
    a_force_en = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 4'b0001) begin
      errors++; $display("FAIL force_resume actual %b required 0001", a_in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (a_out_sel !== 2'd0 || a_out_valid !== 1'b1) begin
      errors++; $display("FAIL force_resume_out actual s=%0d v=%b required 0 1", a_out_sel, a_out_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_in_valid = 4'h0; a_out_ready = 1'b0;
    #1 reset = 1'b1; a_in_valid = 4'b1000;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_out_sel !== 2'd0 || a_in_ready !== 4'b0000) begin
      errors++; $display("FAIL async_reset actual v=%b d=%h s=%0d r=%b required 0 0 0 0000", a_out_valid, a_out_data, a_out_sel, a_in_ready);
    end
    #1 reset = 1'b0; a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 4'b1000) begin
      errors++; $display("FAIL async_release_ready actual %b required 1000", a_in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sel !== 2'd3 || a_out_data !== 16'hA003) begin
      errors++; $display("FAIL async_release_out actual v=%b s=%0d d=%h required 1 3 a003", a_out_valid, a_out_sel, a_out_data);
    end
    @(negedge clk);
    a_in_valid = 4'h0;
  endtask

  task automatic test_random();
    logic [11:0] sb[$];
    logic [11:0] exp_beat;
    int wait_cnt[16];
    int max_wait;
    max_wait = 0;
    for (int j = 0; j < 16; j++) wait_cnt[j] = 0;
    for (int cyc = 0; cyc < 10001; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        c_in_valid  = 16'($urandom | $urandom | $urandom);
        c_in_data   = {$urandom, $urandom, $urandom, $urandom};
        c_out_ready = ($urandom_range(3) != 0);
      end else begin
        c_in_valid = '0; c_out_ready = 1'b1;
      end
      #1;
      if (c_out_valid && c_out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sb_underflow cycle %0d actual extra beat s=%0d required none", cyc, c_out_sel);
        end else begin
          exp_beat = sb.pop_front();
          if ({c_out_sel, c_out_data} !== exp_beat) begin
            errors++; $display("FAIL sb_beat cycle %0d actual %h required %h", cyc, {c_out_sel, c_out_data}, exp_beat);
          end
        end
      end
      checks++;
      if ((c_in_ready & ~c_in_valid) != 0 || !(c_in_ready == 0 || $onehot(c_in_ready)) ||
          (((!c_out_valid || c_out_ready) && c_in_valid != 0) != (c_in_ready != 0))) begin
        errors++; $display("FAIL rand_grant cycle %0d actual ready=%h required onehot grant within valid=%h", cyc, c_in_ready, c_in_valid);
      end
      for (int j = 0; j < 16; j++) begin
        if (c_in_ready[j]) begin
          sb.push_back({4'(j), c_in_data[j*8 +: 8]});
          wait_cnt[j] = 0;
        end else if (!c_in_valid[j]) begin
          wait_cnt[j] = 0;
        end else if (c_in_ready != 0) begin
          wait_cnt[j]++;
          if (wait_cnt[j] > max_wait) max_wait = wait_cnt[j];
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0 || c_out_valid !== 1'b0) begin
      errors++; $display("FAIL sb_drain actual pending=%0d v=%b required 0 0", sb.size(), c_out_valid);
    end
    checks++;
    if (max_wait > 15) begin
      errors++; $display("FAIL starvation actual %0d required <=15", max_wait);
    end
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_fixed_priority();
    test_backpressure();
    test_force();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1);
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning bits per data channel.
REQ-002 The block SHALL have parameter N, default 16, meaning number of input channels; legal values are 2, 4, 8 or 16.
REQ-003 The block SHALL have parameter RR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with channel 0 highest.
REQ-004 The block SHALL define SW = log2(N) as a derived width.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port in_valid, input, N bits: bit i set means channel i offers a beat.
REQ-008 Port in_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port in_ready, output, N bits: bit i set means channel i's beat is accepted this cycle.
REQ-010 Port force_en, input, 1 bit: override mode; only channel force_sel is eligible for grant.
REQ-011 Port force_sel, input, SW bits: channel eligible while force_en is set.
REQ-012 Port out_valid, output, 1 bit: the output register holds a beat.
REQ-013 Port out_data, output, WIDTH bits: the registered beat.
REQ-014 Port out_sel, output, SW bits: source channel index of the registered beat.
REQ-015 Port out_ready, input, 1 bit: the consumer takes the beat when out_valid and out_ready are both set.

Function
REQ-016 The eligible vector SHALL be in_valid when force_en=0, and in_valid masked to bit force_sel when force_en=1.
REQ-017 load_en SHALL be asserted when out_valid=0 or out_ready=1.
REQ-018 When load_en=1 and any eligible bit is set, exactly one channel g SHALL be granted; otherwise none.
REQ-019 In RR=1 mode, g SHALL be the first eligible index found searching upward from pointer ptr, wrapping from N-1 to 0.
REQ-020 In RR=0 mode, g SHALL be the lowest eligible index; ptr SHALL remain 0.
REQ-021 in_ready SHALL be one-hot at bit g on a grant and all-zero otherwise; it SHALL be combinational from the current inputs and state.
REQ-022 in_ready SHALL never depend combinationally on in_data.
REQ-023 On a grant, the next edge SHALL load out_data from channel g, load out_sel with g, and set out_valid=1, giving a latency of 1 cycle.
REQ-024 On a grant in RR=1 mode, ptr SHALL become (g+1) mod N; ptr SHALL be unchanged on any cycle without a grant.
REQ-025 When out_valid=1, out_ready=1 and there is no grant, out_valid SHALL clear at the next edge; out_data and out_sel SHALL hold their values.
REQ-026 When out_valid=1 and out_ready=0, out_valid, out_data and out_sel SHALL all hold, and in_ready SHALL be all-zero.
REQ-027 A simultaneous consume and grant SHALL replace the beat in the same edge, sustaining 1 beat per cycle with no bubble.
REQ-028 A force_en change SHALL take effect in the same cycle's arbitration and SHALL not disturb a held output beat.
REQ-029 The block SHALL never drop or duplicate a beat: each in_valid&in_ready pair produces exactly one out_valid&out_ready pair, in grant order.
REQ-030 A channel that drops in_valid before it is granted SHALL lose no state; no request memory exists.

Reset
REQ-031 While reset=1, regardless of clk, the block SHALL force out_valid=0, out_data=0, out_sel=0 and ptr=0.
REQ-032 While reset=1, in_ready SHALL be all-zero.
REQ-033 Reset asserted mid-transfer SHALL discard the held beat; the first grant after release SHALL search from channel 0.

Verification
REQ-034 The bench SHALL cover this scenario: N=4, RR=1, in_valid=4'b1111, out_ready=1 held -> out_sel sequence 0,1,2,3,0 on consecutive cycles, with out_valid continuously 1 after the first edge.
REQ-035 The bench SHALL cover this scenario: N=4, RR=0, in_valid=4'b1010 held, out_ready=1 -> every beat has out_sel=1, and channel 3 never receives in_ready.
REQ-036 The bench SHALL cover this scenario: one beat 16'hBEEF is granted on channel 2, then out_ready=0 for 3 cycles -> out_valid=1 and out_data=16'hBEEF hold, in_ready=0 throughout, and the beat is consumed on the first out_ready=1.
REQ-037 The bench SHALL cover this scenario: force_en=1, force_sel=3, in_valid=4'b1111 -> only in_ready[3] pulses; after force_en=0 in RR mode, arbitration resumes from ptr=0.
REQ-038 The bench SHALL cover this scenario: reset pulsed asynchronously between clock edges while out_valid=1 -> out_valid, out_data and out_sel read 0 before the next edge; after release with in_valid=4'b1000, out_sel=3.
REQ-039 The bench SHALL cover this scenario: N=16, WIDTH=8 with random valid and ready over 10k cycles -> a scoreboard confirms REQ-029 and that no granted channel is starved beyond N grants in RR mode.
